msg_payload_writer: RTL and testbench
=====================================

Name: msg_payload_writer

Overview:
- Sits directly downstream of the serial message receiver.
- Consumes its byte stream (msg byte, particle/map type flags, data_valid strobe) and packs payload bytes big-endian into fixed-width words.
- Writes the packed words into the particle buffer or map buffer through simple synchronous write ports.
- Reports per-message completion and framing errors to the particle-filter control logic.

Parameters:
- PARTICLE_MESSAGE_LENGTH, 8, payload bytes per particle message
- MAP_MESSAGE_LENGTH, 16, payload bytes per map message
- PARTICLE_WORD_BYTES, 4, bytes per particle buffer word; must divide PARTICLE_MESSAGE_LENGTH
- MAP_WORD_BYTES, 2, bytes per map buffer word; must divide MAP_MESSAGE_LENGTH

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- msg_in  in  8  payload byte from receiver
- particle_data_flag  in  1  particle message in progress
- map_data_flag  in  1  map message in progress
- data_valid  in  1  one-cycle strobe, msg_in valid
- particle_wr_en  out  1  particle buffer write strobe
- particle_wr_addr  out  clog2(PARTICLE_MESSAGE_LENGTH/PARTICLE_WORD_BYTES) (min 1)  word address
- particle_wr_data  out  8*PARTICLE_WORD_BYTES  packed word
- map_wr_en  out  1  map buffer write strobe
- map_wr_addr  out  clog2(MAP_MESSAGE_LENGTH/MAP_WORD_BYTES) (min 1)  word address
- map_wr_data  out  8*MAP_WORD_BYTES  packed word
- particle_load_done  out  1  one-cycle pulse, full particle message written
- map_load_done  out  1  one-cycle pulse, full map message written
- frame_error  out  1  sticky error, cleared at next message start

Behaviour:
- Reset (async): all outputs 0; byte/word counters 0; state IDLE.
- FSM states:
  - IDLE: waiting for a message.
  - PART: collecting a particle message.
  - MAP: collecting a map message.
  - DRAIN: recovery after an error.
- IDLE -> PART on particle_data_flag=1 and map_data_flag=0. IDLE -> MAP on the converse. On entry: byte counter, shift register and word address cleared; frame_error cleared.
- Both flags 1 in IDLE: frame_error<=1, go to DRAIN.
- In PART/MAP, each data_valid cycle: byte shifted into LSB end of a shift register (first byte ends up in the MSBs); byte counter increments.
- Word completion: the byte completing a word on the data_valid at cycle N gives, at cycle N+1:
  - *_wr_en=1 for exactly one cycle;
  - *_wr_data = packed word;
  - *_wr_addr = current word index.
  - The word index then increments. Latency is 1 cycle.
- Message completion: on the final byte (count reaches the message length), *_load_done pulses in the same cycle as the last *_wr_en; FSM -> DRAIN.
- Flag falls in PART/MAP before the full length arrives:
  - partial word discarded; no write, no done;
  - frame_error<=1; -> IDLE.
- DRAIN: further data_valid bytes are dropped. data_valid in DRAIN while a flag is still high sets frame_error. Exit to IDLE only when both flags are 0.
- data_valid in IDLE with no flag: ignored, frame_error<=1.
- Opposite flag rising while in PART/MAP: treated as a protocol error; frame_error<=1, current message aborted, -> DRAIN.
- data_valid and flag fall in the same cycle: the byte is accepted first, then the flag fall is evaluated. If that byte completes the message, the message is treated as complete.
- Address never wraps within a message; it restarts at 0 on every new message.
- Reset mid-message: everything clears. The buffer may hold partially written words; no done pulse is produced.

Decomposition:
- Shared package (msg_pkg):
  - message length and word-size constants;
  - derived words-per-message and address widths;
  - FSM state encoding.
- Natural sub-module: msg_byte_packer, a parameterised shift register plus byte counter.
  - Outputs word_ready and word.
  - Instantiated once per buffer type (two instances, selected by state).

Test Plan:
1. Particle message, 8 bytes 0x01..0x08 on consecutive data_valid strobes -> writes addr0=0x01020304, addr1=0x05060708; particle_load_done coincides with the second wr_en; frame_error=0.
2. Map message, 16 bytes 0xA0..0xAF with 3-cycle gaps -> 8 map writes, addr0=0xA0A1 … addr7=0xAEAF; map_load_done once; no particle writes.
3. Particle flag drops after 5 bytes -> only addr0 written; no done pulse; frame_error=1. The next valid particle message clears frame_error and writes from addr0.
4. Both flags high in IDLE with 4 data_valid bytes -> no writes, frame_error=1; returns to IDLE after both flags go low.
5. Reset asserted after byte 6 of a particle message -> all outputs 0 asynchronously. A following complete message writes addr0/addr1 correctly.
6. 10 data_valid bytes during one particle flag window -> 2 writes plus done after byte 8; bytes 9–10 dropped in DRAIN; frame_error=1.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared constants, width helper and FSM encoding for the message payload writer.
package msg_pkg;

    localparam int DEF_PARTICLE_MESSAGE_LENGTH = 8;
    localparam int DEF_MAP_MESSAGE_LENGTH      = 16;
    localparam int DEF_PARTICLE_WORD_BYTES     = 4;
    localparam int DEF_MAP_WORD_BYTES          = 2;

    // A buffer with a single word still needs a one-bit address port.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int DEF_PARTICLE_WORDS  = DEF_PARTICLE_MESSAGE_LENGTH / DEF_PARTICLE_WORD_BYTES;
    localparam int DEF_MAP_WORDS       = DEF_MAP_MESSAGE_LENGTH / DEF_MAP_WORD_BYTES;
    localparam int DEF_PARTICLE_ADDR_W = addr_width(DEF_PARTICLE_WORDS);
    localparam int DEF_MAP_ADDR_W      = addr_width(DEF_MAP_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PART  = 2'd1,
        ST_MAP   = 2'd2,
        ST_DRAIN = 2'd3
    } wr_state_e;

endpackage

// File: rtl/msg_byte_packer.sv
// Big-endian byte packer: shifts bytes into a word and tracks word index and message byte count.
module msg_byte_packer
    import msg_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int MSG_LEN    = 8,
    parameter int IDX_W      = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic [7:0]              byte_in,
    output logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word,
    output logic [IDX_W-1:0]        word_idx,
    output logic                    msg_done
);

    localparam int HOLD_W = (WORD_BYTES > 1) ? 8 * (WORD_BYTES - 1) : 8;
    localparam int POS_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CNT_W  = $clog2(MSG_LEN + 1);

    logic [HOLD_W-1:0] hold_q, hold_cur, hold_next;
    logic [POS_W-1:0]  pos_q, pos_cur;
    logic [CNT_W-1:0]  cnt_q, cnt_cur;
    logic [IDX_W-1:0]  idx_q, idx_cur;

    // A clear in the same cycle as a byte starts the new message with that byte.
    assign hold_cur = clear ? '0 : hold_q;
    assign pos_cur  = clear ? '0 : pos_q;
    assign cnt_cur  = clear ? '0 : cnt_q;
    assign idx_cur  = clear ? '0 : idx_q;

    generate
        if (WORD_BYTES == 1) begin : g_single
            assign word      = byte_in;
            assign hold_next = hold_cur;
        end else begin : g_multi
            assign word      = {hold_cur, byte_in};
            assign hold_next = word[HOLD_W-1:0];
        end
    endgenerate

    assign word_ready = shift_en && (pos_cur == POS_W'(WORD_BYTES - 1));
    assign msg_done   = shift_en && (cnt_cur == CNT_W'(MSG_LEN - 1));
    assign word_idx   = idx_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            pos_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else if (shift_en) begin
            hold_q <= hold_next;
            cnt_q  <= cnt_cur + CNT_W'(1);
            if (word_ready) begin
                pos_q <= '0;
                idx_q <= msg_done ? idx_cur : idx_cur + IDX_W'(1);
            end else begin
                pos_q <= pos_cur + POS_W'(1);
                idx_q <= idx_cur;
            end
        end else if (clear) begin
            hold_q <= '0;
            pos_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end
    end

endmodule

// File: rtl/msg_payload_writer.sv
// Packs receiver payload bytes into particle/map buffer words and reports completion and framing errors.
module msg_payload_writer
    import msg_pkg::*;
#(
    parameter int PARTICLE_MESSAGE_LENGTH = DEF_PARTICLE_MESSAGE_LENGTH,
    parameter int MAP_MESSAGE_LENGTH      = DEF_MAP_MESSAGE_LENGTH,
    parameter int PARTICLE_WORD_BYTES     = DEF_PARTICLE_WORD_BYTES,
    parameter int MAP_WORD_BYTES          = DEF_MAP_WORD_BYTES
)(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [7:0]                             msg_in,
    input  logic                                   particle_data_flag,
    input  logic                                   map_data_flag,
    input  logic                                   data_valid,
    output logic                                   particle_wr_en,
    output logic [addr_width(PARTICLE_MESSAGE_LENGTH/PARTICLE_WORD_BYTES)-1:0] particle_wr_addr,
    output logic [8*PARTICLE_WORD_BYTES-1:0]       particle_wr_data,
    output logic                                   map_wr_en,
    output logic [addr_width(MAP_MESSAGE_LENGTH/MAP_WORD_BYTES)-1:0] map_wr_addr,
    output logic [8*MAP_WORD_BYTES-1:0]            map_wr_data,
    output logic                                   particle_load_done,
    output logic                                   map_load_done,
    output logic                                   frame_error
);

    localparam int P_ADDR_W = addr_width(PARTICLE_MESSAGE_LENGTH / PARTICLE_WORD_BYTES);
    localparam int M_ADDR_W = addr_width(MAP_MESSAGE_LENGTH / MAP_WORD_BYTES);
    localparam int P_DATA_W = 8 * PARTICLE_WORD_BYTES;
    localparam int M_DATA_W = 8 * MAP_WORD_BYTES;

    wr_state_e state_q, state_d;

    logic part_clear, part_shift, part_word_ready, part_msg_done;
    logic map_clear, map_shift, map_word_ready, map_msg_done;
    logic set_err, clr_err;
    logic [P_DATA_W-1:0] part_word;
    logic [M_DATA_W-1:0] map_word;
    logic [P_ADDR_W-1:0] part_idx;
    logic [M_ADDR_W-1:0] map_idx;

    msg_byte_packer #(
        .WORD_BYTES(PARTICLE_WORD_BYTES),
        .MSG_LEN   (PARTICLE_MESSAGE_LENGTH),
        .IDX_W     (P_ADDR_W)
    ) u_part_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (part_clear),
        .shift_en  (part_shift),
        .byte_in   (msg_in),
        .word_ready(part_word_ready),
        .word      (part_word),
        .word_idx  (part_idx),
        .msg_done  (part_msg_done)
    );

    msg_byte_packer #(
        .WORD_BYTES(MAP_WORD_BYTES),
        .MSG_LEN   (MAP_MESSAGE_LENGTH),
        .IDX_W     (M_ADDR_W)
    ) u_map_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (map_clear),
        .shift_en  (map_shift),
        .byte_in   (msg_in),
        .word_ready(map_word_ready),
        .word      (map_word),
        .word_idx  (map_idx),
        .msg_done  (map_msg_done)
    );

    // A byte arriving with the flag fall is accepted first, so completion wins over the abort.
    always_comb begin
        state_d    = state_q;
        part_clear = 1'b0;
        part_shift = 1'b0;
        map_clear  = 1'b0;
        map_shift  = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (particle_data_flag && map_data_flag) begin
                    set_err = 1'b1;
                    state_d = ST_DRAIN;
                end else if (particle_data_flag) begin
                    part_clear = 1'b1;
                    part_shift = data_valid;
                    clr_err    = 1'b1;
                    state_d    = ST_PART;
                end else if (map_data_flag) begin
                    map_clear = 1'b1;
                    map_shift = data_valid;
                    clr_err   = 1'b1;
                    state_d   = ST_MAP;
                end else if (data_valid) begin
                    set_err = 1'b1;
                end
            end
            ST_PART: begin
                if (map_data_flag) begin
                    set_err = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    part_shift = data_valid;
                    if (part_msg_done) begin
                        state_d = ST_DRAIN;
                    end else if (!particle_data_flag) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MAP: begin
                if (particle_data_flag) begin
                    set_err = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    map_shift = data_valid;
                    if (map_msg_done) begin
                        state_d = ST_DRAIN;
                    end else if (!map_data_flag) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (data_valid && (particle_data_flag || map_data_flag)) begin
                    set_err = 1'b1;
                end
                if (!particle_data_flag && !map_data_flag) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write ports are registered, giving one cycle from the completing byte to the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            particle_wr_en     <= 1'b0;
            particle_wr_addr   <= '0;
            particle_wr_data   <= '0;
            map_wr_en          <= 1'b0;
            map_wr_addr        <= '0;
            map_wr_data        <= '0;
            particle_load_done <= 1'b0;
            map_load_done      <= 1'b0;
            frame_error        <= 1'b0;
        end else begin
            particle_wr_en     <= part_word_ready;
            map_wr_en          <= map_word_ready;
            particle_load_done <= part_msg_done;
            map_load_done      <= map_msg_done;
            if (part_word_ready) begin
                particle_wr_addr <= part_idx;
                particle_wr_data <= part_word;
            end
            if (map_word_ready) begin
                map_wr_addr <= map_idx;
                map_wr_data <= map_word;
            end
            if (set_err) begin
                frame_error <= 1'b1;
            end else if (clr_err) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msg_payload_writer.sv
// Directed self-checking bench for msg_payload_writer with a write-logging monitor.
module tb_msg_payload_writer;

    logic        clk;
    logic        reset;
    logic [7:0]  msg_in;
    logic        particle_data_flag;
    logic        map_data_flag;
    logic        data_valid;
    logic        particle_wr_en;
    logic [0:0]  particle_wr_addr;
    logic [31:0] particle_wr_data;
    logic        map_wr_en;
    logic [2:0]  map_wr_addr;
    logic [15:0] map_wr_data;
    logic        particle_load_done;
    logic        map_load_done;
    logic        frame_error;

    int num_checks = 0;
    int num_fail   = 0;

    logic [31:0] p_addr_q[$];
    logic [31:0] p_data_q[$];
    logic [31:0] m_addr_q[$];
    logic [31:0] m_data_q[$];
    int p_done_cnt;
    int m_done_cnt;
    int p_done_idx;

    msg_payload_writer dut (
        .clk               (clk),
        .reset             (reset),
        .msg_in            (msg_in),
        .particle_data_flag(particle_data_flag),
        .map_data_flag     (map_data_flag),
        .data_valid        (data_valid),
        .particle_wr_en    (particle_wr_en),
        .particle_wr_addr  (particle_wr_addr),
        .particle_wr_data  (particle_wr_data),
        .map_wr_en         (map_wr_en),
        .map_wr_addr       (map_wr_addr),
        .map_wr_data       (map_wr_data),
        .particle_load_done(particle_load_done),
        .map_load_done     (map_load_done),
        .frame_error       (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (particle_wr_en) begin
            p_addr_q.push_back(32'(particle_wr_addr));
            p_data_q.push_back(particle_wr_data);
        end
        if (map_wr_en) begin
            m_addr_q.push_back(32'(map_wr_addr));
            m_data_q.push_back(32'(map_wr_data));
        end
        if (particle_load_done) begin
            p_done_cnt = p_done_cnt + 1;
            p_done_idx = particle_wr_en ? p_data_q.size() : -1;
        end
        if (map_load_done) m_done_cnt = m_done_cnt + 1;
    end

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        msg_in     = b;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks = num_checks + 1;
        assert (observed === expected) else begin
            num_fail = num_fail + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        p_addr_q.delete();
        p_data_q.delete();
        m_addr_q.delete();
        m_data_q.delete();
        p_done_cnt = 0;
        m_done_cnt = 0;
        p_done_idx = -1;
    endtask

    initial begin
        reset = 1'b1;
        msg_in = 8'h00;
        particle_data_flag = 1'b0;
        map_data_flag = 1'b0;
        data_valid = 1'b0;
        clearLog();
        tick(2);
        checkOutput("rst_p_wr_en", 32'(particle_wr_en), 32'd0);
        checkOutput("rst_p_wr_data", particle_wr_data, 32'd0);
        checkOutput("rst_m_wr_en", 32'(map_wr_en), 32'd0);
        checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
        reset = 1'b0;
        tick(1);

        $display("[TB] particle message 01..08");
        particle_data_flag = 1'b1;
        tick(1);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 0);
        tick(2);
        checkOutput("t1_nwrites", 32'(p_data_q.size()), 32'd2);
        checkOutput("t1_addr0", qget(p_addr_q, 0), 32'd0);
        checkOutput("t1_data0", qget(p_data_q, 0), 32'h01020304);
        checkOutput("t1_addr1", qget(p_addr_q, 1), 32'd1);
        checkOutput("t1_data1", qget(p_data_q, 1), 32'h05060708);
        checkOutput("t1_done_cnt", 32'(p_done_cnt), 32'd1);
        checkOutput("t1_done_with_wr2", 32'(p_done_idx), 32'd2);
        checkOutput("t1_frame_error", 32'(frame_error), 32'd0);
        particle_data_flag = 1'b0;
        tick(2);

        $display("[TB] map message A0..AF with gaps");
        clearLog();
        map_data_flag = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) applyStimulus(8'hA0 + 8'(i), 3);
        tick(2);
        checkOutput("t2_nwrites", 32'(m_data_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_addr%0d", i), qget(m_addr_q, i), 32'(i));
            checkOutput($sformatf("t2_data%0d", i), qget(m_data_q, i),
                        {16'h0, 8'hA0 + 8'(2 * i), 8'hA1 + 8'(2 * i)});
        end
        checkOutput("t2_done_cnt", 32'(m_done_cnt), 32'd1);
        checkOutput("t2_no_particle", 32'(p_data_q.size()), 32'd0);
        map_data_flag = 1'b0;
        tick(2);

        $display("[TB] particle flag drops after 5 bytes");
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 0);
        particle_data_flag = 1'b0;
        tick(3);
        checkOutput("t3_nwrites", 32'(p_data_q.size()), 32'd1);
        checkOutput("t3_data0", qget(p_data_q, 0), 32'h01020304);
        checkOutput("t3_done_cnt", 32'(p_done_cnt), 32'd0);
        checkOutput("t3_frame_error", 32'(frame_error), 32'd1);
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        checkOutput("t3_err_cleared", 32'(frame_error), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(8'h11 + 8'(i), 0);
        tick(2);
        checkOutput("t3_re_addr0", qget(p_addr_q, 0), 32'd0);
        checkOutput("t3_re_data0", qget(p_data_q, 0), 32'h11121314);
        checkOutput("t3_re_data1", qget(p_data_q, 1), 32'h15161718);
        particle_data_flag = 1'b0;
        tick(2);

        $display("[TB] both flags high in idle");
        clearLog();
        particle_data_flag = 1'b1;
        map_data_flag = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) applyStimulus(8'h55, 0);
        tick(2);
        checkOutput("t4_p_writes", 32'(p_data_q.size()), 32'd0);
        checkOutput("t4_m_writes", 32'(m_data_q.size()), 32'd0);
        checkOutput("t4_frame_error", 32'(frame_error), 32'd1);
        particle_data_flag = 1'b0;
        map_data_flag = 1'b0;
        tick(2);

        $display("[TB] reset in mid message");
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        checkOutput("t5_idle_entry", 32'(frame_error), 32'd0);
        for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 0);
        checkOutput("t5_pre_rst_data", particle_wr_data, 32'h01020304);
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_wr_en", 32'(particle_wr_en), 32'd0);
        checkOutput("t5_rst_wr_data", particle_wr_data, 32'd0);
        checkOutput("t5_rst_done", 32'(particle_load_done), 32'd0);
        particle_data_flag = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) applyStimulus(8'h21 + 8'(i), 0);
        tick(2);
        checkOutput("t5_addr0", qget(p_addr_q, 0), 32'd0);
        checkOutput("t5_data0", qget(p_data_q, 0), 32'h21222324);
        checkOutput("t5_addr1", qget(p_addr_q, 1), 32'd1);
        checkOutput("t5_data1", qget(p_data_q, 1), 32'h25262728);
        checkOutput("t5_done_cnt", 32'(p_done_cnt), 32'd1);
        particle_data_flag = 1'b0;
        tick(2);

        $display("[TB] ten bytes in one particle window");
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) applyStimulus(8'h31 + 8'(i), 0);
        tick(2);
        checkOutput("t6_nwrites", 32'(p_data_q.size()), 32'd2);
        checkOutput("t6_data0", qget(p_data_q, 0), 32'h31323334);
        checkOutput("t6_data1", qget(p_data_q, 1), 32'h35363738);
        checkOutput("t6_done_cnt", 32'(p_done_cnt), 32'd1);
        checkOutput("t6_frame_error", 32'(frame_error), 32'd1);
        particle_data_flag = 1'b0;
        tick(2);
        checkOutput("t6_err_sticky", 32'(frame_error), 32'd1);

        $display("[TB] last byte with flag fall");
        clearLog();
        particle_data_flag = 1'b1;
        tick(1);
        checkOutput("t7_err_cleared", 32'(frame_error), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(8'h41 + 8'(i), 0);
        msg_in = 8'h48;
        data_valid = 1'b1;
        particle_data_flag = 1'b0;
        tick(1);
        data_valid = 1'b0;
        tick(2);
        checkOutput("t7_nwrites", 32'(p_data_q.size()), 32'd2);
        checkOutput("t7_data1", qget(p_data_q, 1), 32'h45464748);
        checkOutput("t7_done_cnt", 32'(p_done_cnt), 32'd1);
        checkOutput("t7_frame_error", 32'(frame_error), 32'd0);

        $display("[TB] data_valid in idle without a flag");
        clearLog();
        applyStimulus(8'h99, 2);
        checkOutput("t8_frame_error", 32'(frame_error), 32'd1);
        checkOutput("t8_p_writes", 32'(p_data_q.size()), 32'd0);
        checkOutput("t8_m_writes", 32'(m_data_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fail);
        $finish;
    end

endmodule
